// File: rtl/segre_pkg.sv
// Shared lane geometry and FSM state type for the memory lane server and dcache.
package segre_pkg;

   localparam int WORD_SIZE      = 32;
   localparam int LANE_BYTES     = 16;
   localparam int LANE_SIZE      = LANE_BYTES * 8;
   localparam int ADDR_BYTE_SIZE = $clog2(LANE_BYTES);

   typedef enum logic [1:0] {
      MEM_IDLE,
      MEM_WAIT,
      MEM_RESP
   } mem_state_e;

endpackage

// File: rtl/segre_mem_lane_array.sv
// Lane-wide backing store: one synchronous read/write port, all lanes cleared
// asynchronously by reset. The read register only loads on a read access, so
// it holds the last lane read until the next one.
module segre_mem_lane_array #(
   parameter int LANES = 256,
   parameter int WIDTH = 128,
   parameter int IDX_W = 8
) (
   input  logic             clk_i,
   input  logic             rsn_i,
   input  logic             en,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] lanes_reg [LANES];
   logic [WIDTH-1:0] rdata_reg;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         // Each lane clears on reset and loads on a write addressed to it.
         always_ff @(posedge clk_i or negedge rsn_i) begin
            if (!rsn_i) begin
               lanes_reg[gi] <= '0;
            end else if (en && we && (idx == IDX_W'(gi))) begin
               lanes_reg[gi] <= wdata;
            end
         end
      end
   endgenerate

   // Registered read of the addressed lane on a read access.
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         rdata_reg <= '0;
      end else if (en && !we) begin
         rdata_reg <= lanes_reg[idx];
      end
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/segre_mem_lane_server.sv
// Memory-side lane responder: accepts one lane read/write, waits LATENCY
// cycles, then commits the write or pulses the read lane to the cache.
module segre_mem_lane_server
   import segre_pkg::*;
#(
   parameter int BYTES_PER_LANE = LANE_BYTES,
   parameter int MEM_LANES      = 256,
   parameter int LATENCY        = 4
) (
   input  logic                        clk_i,
   input  logic                        rsn_i,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  logic                        req_we_i,
   input  logic [WORD_SIZE-1:0]        req_addr_i,
   input  logic [BYTES_PER_LANE*8-1:0] req_data_i,
   output logic                        rsp_valid_o,
   output logic [WORD_SIZE-1:0]        rsp_addr_o,
   output logic [BYTES_PER_LANE*8-1:0] rsp_data_o,
   output logic                        wr_done_o,
   output logic                        busy_o
);

   localparam int LANE_W = BYTES_PER_LANE * 8;
   localparam int OFF_W  = $clog2(BYTES_PER_LANE);
   localparam int IDX_W  = $clog2(MEM_LANES);
   localparam int CNT_W  = $clog2(LATENCY + 1);
   localparam logic [WORD_SIZE-1:0] OFF_MASK = WORD_SIZE'((64'd1 << OFF_W) - 64'd1);

   mem_state_e        state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              we_reg;
   logic [WORD_SIZE-1:0] addr_reg;
   logic [WORD_SIZE-1:0] rsp_addr_reg;
   logic [LANE_W-1:0] data_reg;
   logic              accept;
   logic              commit;

   assign accept = (state_reg == MEM_IDLE) && req_valid_i;
   // The array access happens on the edge that leaves WAIT.
   assign commit = (state_reg == MEM_WAIT) && (cnt_reg == '0);

   // State and latency counter registers.
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         state_reg <= MEM_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next-state and counter decode.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         MEM_IDLE: begin
            if (req_valid_i) begin
               state_next = MEM_WAIT;
               cnt_next   = CNT_W'(LATENCY - 1);
            end
         end
         MEM_WAIT: begin
            if (cnt_reg == '0) begin
               state_next = MEM_RESP;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         MEM_RESP: begin
            state_next = MEM_IDLE;
         end
         default: begin
            state_next = MEM_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Capture the request on accept; address is stored lane-aligned.
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         we_reg   <= 1'b0;
         addr_reg <= '0;
         data_reg <= '0;
      end else if (accept) begin
         we_reg   <= req_we_i;
         addr_reg <= req_addr_i & ~OFF_MASK;
         data_reg <= req_data_i;
      end
   end

   // Response address follows the read that is being returned and holds after.
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         rsp_addr_reg <= '0;
      end else if (commit && !we_reg) begin
         rsp_addr_reg <= addr_reg;
      end
   end

   segre_mem_lane_array #(
      .LANES (MEM_LANES),
      .WIDTH (LANE_W),
      .IDX_W (IDX_W)
   ) u_array (
      .clk_i (clk_i),
      .rsn_i (rsn_i),
      .en    (commit),
      .we    (we_reg),
      .idx   (addr_reg[OFF_W +: IDX_W]),
      .wdata (data_reg),
      .rdata (rsp_data_o)
   );

   assign req_ready_o = (state_reg == MEM_IDLE);
   assign busy_o      = (state_reg != MEM_IDLE);
   assign rsp_valid_o = (state_reg == MEM_RESP) && !we_reg;
   assign wr_done_o   = (state_reg == MEM_RESP) && we_reg;
   assign rsp_addr_o  = rsp_addr_reg;

endmodule
